// File: rtl/nanov_reg_writer_pkg.sv
// Shared types for the serial register-file write-back path.
// Counter-aligned word layout, writer states and FIFO entry format.
package nanov_reg_writer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;
  localparam int REG_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } writer_state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/nanov_reg_writer_wb_fifo.sv
// Small synchronous FIFO of {rd, data} write-back requests; head is visible
// combinationally. Pushes while full and pops while empty are ignored.
module nanov_reg_writer_wb_fifo
  import nanov_reg_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset so it can map onto plain flops or a small RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nanov_reg_writer.sv
// Parallel-to-serial write-back port: buffers {rd, word} and shifts it LSB-first on the shared counter.
// Optional macro NANOV_WRITER_X0_FILTER_EN drops x0 requests after the handshake.
module nanov_reg_writer
  import nanov_reg_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] counter,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_rd,
  input  logic [XLEN-1:0]  in_data,
  output logic [REG_W-1:0] rd,
  output logic             wr_en,
  output logic             wr_next_en,
  output logic             rd_bit,
  output logic             rd_next_bit,
  output logic             busy
);

  writer_state_t    state;
  logic [XLEN-1:0]  active;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             cnt_last;
  logic [CNT_W-1:0] next_idx;

  assign cnt_last   = (counter == CNT_LAST);
  assign next_idx   = counter + CNT_W'(1);
  assign in_ready   = !full;
  assign push_entry = '{rd: in_rd, data: in_data};

`ifdef NANOV_WRITER_X0_FILTER_EN
  // x0 completes the handshake but never occupies a slot.
  assign push = in_valid && in_ready && (in_rd != '0);
`else
  assign push = in_valid && in_ready;
`endif

  // Load from IDLE, or chain straight into the next word at the last bit.
  assign pop  = !empty && ((state == IDLE) || ((state == SHIFT) && cnt_last));
  assign busy = (state != IDLE) || !empty;

  nanov_reg_writer_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      active <= '0;
      rd     <= '0;
    end else begin
      if (pop) begin
        active <= head.data;
        rd     <= head.rd;
      end
      case (state)
        IDLE:    if (!empty) state <= ARMED;
        ARMED:   if (cnt_last) state <= SHIFT;
        SHIFT:   if (cnt_last && empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lookahead bit at counter 31 comes from whatever will be loaded at that edge.
  always_comb begin
    wr_en       = 1'b0;
    rd_bit      = 1'b0;
    wr_next_en  = 1'b0;
    rd_next_bit = 1'b0;
    case (state)
      ARMED: begin
        if (cnt_last) begin
          wr_next_en  = 1'b1;
          rd_next_bit = active[0];
        end
      end
      SHIFT: begin
        wr_en  = 1'b1;
        rd_bit = active[counter];
        if (!cnt_last) begin
          wr_next_en  = 1'b1;
          rd_next_bit = active[next_idx];
        end else if (!empty) begin
          wr_next_en  = 1'b1;
          rd_next_bit = head.data[0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nanov_reg_writer.sv
// Directed bench for nanov_reg_writer: the bench owns the bit counter and
// captures every serialised word at the negative edge.
module tb_nanov_reg_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  counter;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [31:0] in_data;
  logic [3:0]  rd;
  logic        wr_en;
  logic        wr_next_en;
  logic        rd_bit;
  logic        rd_next_bit;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [35:0] got_q[$];
  logic [31:0] mon_word = '0;
  int          wr_cycles = 0;

  nanov_reg_writer #(.FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .counter    (counter),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .rd         (rd),
    .wr_en      (wr_en),
    .wr_next_en (wr_next_en),
    .rd_bit     (rd_bit),
    .rd_next_bit(rd_next_bit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reassemble the serial stream; a word is complete at its counter==31 bit.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mon_word[counter] = rd_bit;
      wr_cycles = wr_cycles + 1;
      if (counter == 5'd31) got_q.push_back({rd, mon_word});
    end
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1 counter = counter + 5'd1;
    #1;
  endtask

  task automatic wait_cnt(input logic [4:0] v);
    int n = 0;
    while (counter != v && n < 40) begin
      next_cycle();
      n++;
    end
  endtask

  task automatic wait_wr(input int limit);
    int n = 0;
    while (wr_en !== 1'b1 && n < limit) begin
      next_cycle();
      n++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      next_cycle();
      n++;
    end
  endtask

  initial begin
    int          base;
    int          bad;
    int          k;
    int          wbase;
    logic [31:0] exp_w;
    logic [35:0] exp_e [5];

    rstn = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; counter = '0;
    next_cycle();
    next_cycle();
    chk("rst_in_ready",    36'(in_ready),    36'(1));
    chk("rst_wr_en",       36'(wr_en),       36'(0));
    chk("rst_wr_next_en",  36'(wr_next_en),  36'(0));
    chk("rst_rd_bit",      36'(rd_bit),      36'(0));
    chk("rst_rd_next_bit", 36'(rd_next_bit), 36'(0));
    chk("rst_busy",        36'(busy),        36'(0));
    chk("rst_rd",          36'(rd),          36'(0));
    rstn = 1'b1;

    // Single word accepted at counter 10.
    wait_cnt(5'd10);
    base = got_q.size();
    exp_w = 32'hA5A5_0F0F;
    in_valid = 1'b1; in_rd = 4'd5; in_data = exp_w;
    next_cycle();
    in_valid = 1'b0;
    chk("t1_busy_pending", 36'(busy),  36'(1));
    chk("t1_no_wr_yet",    36'(wr_en), 36'(0));
    wait_cnt(5'd30);
    chk("t1_armed_next_en_low", 36'(wr_next_en), 36'(0));
    next_cycle();
    chk("t1_next_en_at31",  36'(wr_next_en),  36'(1));
    chk("t1_next_bit_at31", 36'(rd_next_bit), 36'(1));
    chk("t1_armed_no_wr",   36'(wr_en),       36'(0));
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      if (wr_en !== 1'b1 || rd !== 4'd5 || rd_bit !== exp_w[i]) bad++;
      if (i < 31 && (wr_next_en !== 1'b1 || rd_next_bit !== exp_w[i+1])) bad++;
    end
    chk("t1_last_next_en", 36'(wr_next_en), 36'(0));
    chk("t1_shift_bits",   36'(bad),        36'(0));
    next_cycle();
    chk("t1_idle_busy", 36'(busy),  36'(0));
    chk("t1_idle_wr",   36'(wr_en), 36'(0));
    chk("t1_word_count", 36'(got_q.size() - base), 36'(1));
    chk("t1_word", got_q[base], {4'd5, 32'hA5A5_0F0F});

    // Back-to-back words chain with no gap.
    base = got_q.size();
    in_valid = 1'b1; in_rd = 4'd1; in_data = 32'hFFFF_FFFF;
    next_cycle();
    in_rd = 4'd2; in_data = 32'h0000_0001;
    next_cycle();
    in_valid = 1'b0;
    wait_wr(70);
    chk("t2_start",     36'(wr_en),   36'(1));
    chk("t2_start_cnt", 36'(counter), 36'(0));
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) next_cycle();
      if (wr_en !== 1'b1) bad++;
      if (i == 31) begin
        chk("t2_chain_next_en",  36'(wr_next_en),  36'(1));
        chk("t2_chain_next_bit", 36'(rd_next_bit), 36'(1));
        chk("t2_rd_before",      36'(rd),          36'(1));
      end
      if (i == 32) begin
        chk("t2_rd_after",   36'(rd),      36'(2));
        chk("t2_switch_cnt", 36'(counter), 36'(0));
      end
    end
    chk("t2_contiguous", 36'(bad), 36'(0));
    next_cycle();
    chk("t2_end_wr", 36'(wr_en), 36'(0));
    chk("t2_count", 36'(got_q.size() - base), 36'(2));
    chk("t2_w0", got_q[base],     {4'd1, 32'hFFFF_FFFF});
    chk("t2_w1", got_q[base + 1], {4'd2, 32'h0000_0001});

    // Backpressure: four pushes during SHIFT against a 2-entry buffer.
    base = got_q.size();
    in_valid = 1'b1; in_rd = 4'd6; in_data = 32'h0BAD_F00D;
    next_cycle();
    in_valid = 1'b0;
    wait_wr(70);
    chk("t3_start", 36'(wr_en), 36'(1));
    in_valid = 1'b1; in_rd = 4'd7; in_data = 32'h1111_1111;
    next_cycle();
    in_rd = 4'd8; in_data = 32'h2222_2222;
    next_cycle();
    chk("t3_full", 36'(in_ready), 36'(0));
    in_rd = 4'd9; in_data = 32'h3333_3333;
    wait_cnt(5'd31);
    chk("t3_full_at31", 36'(in_ready), 36'(0));
    next_cycle();
    chk("t3_ready_after_pop", 36'(in_ready), 36'(1));
    chk("t3_chain_rd",        36'(rd),       36'(7));
    next_cycle();
    in_rd = 4'd10; in_data = 32'h4444_4444;
    chk("t3_full_again", 36'(in_ready), 36'(0));
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin
      next_cycle();
      k++;
    end
    chk("t3_last_ready", 36'(in_ready), 36'(1));
    next_cycle();
    in_valid = 1'b0;
    k = 0;
    while (got_q.size() - base < 5 && k < 200) begin
      next_cycle();
      k++;
    end
    chk("t3_count", 36'(got_q.size() - base), 36'(5));
    exp_e[0] = {4'd6,  32'h0BAD_F00D};
    exp_e[1] = {4'd7,  32'h1111_1111};
    exp_e[2] = {4'd8,  32'h2222_2222};
    exp_e[3] = {4'd9,  32'h3333_3333};
    exp_e[4] = {4'd10, 32'h4444_4444};
    for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), got_q[base + i], exp_e[i]);

    // Word accepted in IDLE at counter 31 waits a full round in ARMED.
    wait_idle(100);
    wait_cnt(5'd31);
    base = got_q.size();
    in_valid = 1'b1; in_rd = 4'd11; in_data = 32'h1234_5678;
    next_cycle();
    in_valid = 1'b0;
    k = 1;
    chk("t4_cnt0_no_wr", 36'(wr_en), 36'(0));
    next_cycle();
    k = 2;
    chk("t4_armed_busy",    36'(busy),       36'(1));
    chk("t4_armed_next_en", 36'(wr_next_en), 36'(0));
    while (wr_en !== 1'b1 && k < 80) begin
      next_cycle();
      k++;
    end
    chk("t4_latency",   36'(k),       36'(33));
    chk("t4_first_cnt", 36'(counter), 36'(0));
    wait_idle(100);
    chk("t4_word", got_q[base], {4'd11, 32'h1234_5678});

    // Reset at counter 15 of SHIFT with a word queued.
    base = got_q.size();
    in_valid = 1'b1; in_rd = 4'd12; in_data = 32'hCAFE_BABE;
    next_cycle();
    in_valid = 1'b0;
    wait_wr(70);
    in_valid = 1'b1; in_rd = 4'd13; in_data = 32'h5555_AAAA;
    next_cycle();
    in_valid = 1'b0;
    wait_cnt(5'd15);
    chk("t5_in_shift", 36'(wr_en), 36'(1));
    rstn = 1'b0;
    next_cycle();
    chk("t5_wr_en",      36'(wr_en),      36'(0));
    chk("t5_wr_next_en", 36'(wr_next_en), 36'(0));
    chk("t5_busy",       36'(busy),       36'(0));
    chk("t5_in_ready",   36'(in_ready),   36'(1));
    chk("t5_rd",         36'(rd),         36'(0));
    rstn = 1'b1;
    wbase = wr_cycles;
    for (int i = 0; i < 80; i++) next_cycle();
    chk("t5_no_wr_after",   36'(wr_cycles - wbase),     36'(0));
    chk("t5_no_words",      36'(got_q.size() - base),   36'(0));

    // x0 request followed by rd=3.
    base = got_q.size();
    in_valid = 1'b1; in_rd = 4'd0; in_data = 32'hDEAD_BEEF;
    next_cycle();
`ifdef NANOV_WRITER_X0_FILTER_EN
    chk("t6_x0_busy", 36'(busy), 36'(0));
`else
    chk("t6_x0_busy", 36'(busy), 36'(1));
`endif
    in_rd = 4'd3; in_data = 32'h0000_00FF;
    next_cycle();
    in_valid = 1'b0;
    wait_idle(200);
    chk("t6_idle", 36'(busy), 36'(0));
`ifdef NANOV_WRITER_X0_FILTER_EN
    chk("t6_count", 36'(got_q.size() - base), 36'(1));
    chk("t6_w0", got_q[base], {4'd3, 32'h0000_00FF});
`else
    chk("t6_count", 36'(got_q.size() - base), 36'(2));
    chk("t6_w0", got_q[base],     {4'd0, 32'hDEAD_BEEF});
    chk("t6_w1", got_q[base + 1], {4'd3, 32'h0000_00FF});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
